// File: rtl/axi_cmd_pkg.sv
// Shared types and AXI4 constants for the single-beat AXI command master.
// Holds the controller state encoding and the fixed burst attributes it drives.
package axi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0]  BURST_INCR  = 2'b01;
  localparam logic [2:0]  SIZE_4B     = 3'b010;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [7:0]  LEN_SINGLE  = 8'h00;
  localparam logic [3:0]  CACHE_NONE  = 4'b0000;
  localparam logic [2:0]  PROT_NONE   = 3'b000;
  localparam logic [15:0] CYC_MAX     = 16'hFFFF;

  // Saturating increment for the latency counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == CYC_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_cmd_master.sv
// Turns one command at a time into a single-beat AXI4 read or write and returns
// the slave's response (ID-checked) together with the accept-to-response latency.
module axi_cmd_master
  import axi_cmd_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [ID_WIDTH-1:0]   rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [15:0]           rsp_cycles,
  output logic                  busy,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  state_e                state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  write_q, write_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            resp_q, resp_d;
  logic [15:0]           cycles_q, cycles_d;

  logic cmd_hs_s, aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s, rsp_hs_s;
  logic unused_rlast_s;

  // Single-beat reads never need rlast; it is deliberately ignored.
  assign unused_rlast_s = m_axi_rlast;

  assign cmd_hs_s = cmd_valid && cmd_ready;
  assign aw_hs_s  = m_axi_awvalid && m_axi_awready;
  assign w_hs_s   = m_axi_wvalid && m_axi_wready;
  assign b_hs_s   = m_axi_bvalid && m_axi_bready;
  assign ar_hs_s  = m_axi_arvalid && m_axi_arready;
  assign r_hs_s   = m_axi_rvalid && m_axi_rready;
  assign rsp_hs_s = rsp_valid && rsp_ready;

  // Next-state, command latching, response capture and latency counting.
  always_comb begin
    state_d   = state_q;
    write_d   = write_q;
    id_d      = id_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rsp_id_d  = rsp_id_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    cycles_d  = cycles_q;
    case (state_q)
      IDLE: begin
        if (cmd_hs_s) begin
          write_d   = cmd_write;
          id_d      = cmd_id;
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rsp_id_d  = '0;
          rdata_d   = '0;
          resp_d    = RESP_OKAY;
          cycles_d  = 16'd0;
          state_d   = cmd_write ? WR_REQ : RD_REQ;
        end else begin
          state_d = IDLE;
        end
      end
      WR_REQ: begin
        cycles_d  = sat_inc16(cycles_q);
        aw_done_d = aw_done_q || aw_hs_s;
        w_done_d  = w_done_q || w_hs_s;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end else begin
          state_d = WR_REQ;
        end
      end
      WR_RESP: begin
        cycles_d = sat_inc16(cycles_q);
        if (b_hs_s) begin
          rsp_id_d = m_axi_bid;
          rdata_d  = '0;
          resp_d   = (m_axi_bid != id_q) ? RESP_SLVERR : m_axi_bresp;
          state_d  = RSP;
        end else begin
          state_d = WR_RESP;
        end
      end
      RD_REQ: begin
        cycles_d = sat_inc16(cycles_q);
        if (ar_hs_s) begin
          state_d = RD_RESP;
        end else begin
          state_d = RD_REQ;
        end
      end
      RD_RESP: begin
        cycles_d = sat_inc16(cycles_q);
        if (r_hs_s) begin
          rsp_id_d = m_axi_rid;
          rdata_d  = m_axi_rdata;
          resp_d   = (m_axi_rid != id_q) ? RESP_SLVERR : m_axi_rresp;
          state_d  = RSP;
        end else begin
          state_d = RD_RESP;
        end
      end
      RSP: begin
        if (rsp_hs_s) begin
          state_d = IDLE;
        end else begin
          state_d = RSP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered so it stays low throughout reset and rises one edge after release.
    cmd_ready_d = (state_d == IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rsp_id_q    <= '0;
      rdata_q     <= '0;
      resp_q      <= 2'b00;
      cycles_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      write_q     <= write_d;
      id_q        <= id_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rsp_id_q    <= rsp_id_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
      cycles_q    <= cycles_d;
    end
  end

  assign cmd_ready  = cmd_ready_q;
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = (state_q == RSP);
  assign rsp_write  = write_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_resp   = resp_q;
  assign rsp_cycles = cycles_q;

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = LEN_SINGLE;
  assign m_axi_awsize  = SIZE_4B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_NONE;
  assign m_axi_awprot  = PROT_NONE;
  assign m_axi_awvalid = (state_q == WR_REQ) && !aw_done_q;

  assign m_axi_wdata  = wdata_q;
  assign m_axi_wstrb  = wstrb_q;
  assign m_axi_wlast  = 1'b1;
  assign m_axi_wvalid = (state_q == WR_REQ) && !w_done_q;

  assign m_axi_bready = (state_q == WR_RESP);

  assign m_axi_arid    = id_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = LEN_SINGLE;
  assign m_axi_arsize  = SIZE_4B;
  assign m_axi_arburst = BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = CACHE_NONE;
  assign m_axi_arprot  = PROT_NONE;
  assign m_axi_arvalid = (state_q == RD_REQ);

  assign m_axi_rready = (state_q == RD_RESP);

endmodule
